// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: turns the four direction buttons into the registered
// player sprite anchor on the 96x64 grid. Handles fixed-rate stepping, wall
// clamping and the crash/respawn sequence.
// Optional build macro PLAYER_WRAP_EN: x wraps around the screen edges
// instead of clamping (y always clamps).
module player_motion_ctrl #(
    parameter int unsigned STEP_DIV      = 2500000,
    parameter int unsigned X_MAX         = 86,
    parameter int unsigned Y_MAX         = 56,
    parameter int unsigned SPAWN_X       = 0,
    parameter int unsigned SPAWN_Y       = 28,
    parameter int unsigned RESPAWN_STEPS = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       crash_in,
    output logic [6:0] player_x,
    output logic [5:0] player_y,
    output logic       player_moving,
    output logic       player_crashed,
    output logic       respawn_pulse
);

    localparam int unsigned           CW         = $clog2(STEP_DIV);
    localparam logic [CW-1:0]         CNT_LAST   = CW'(STEP_DIV - 1);
    localparam logic [7:0]            CRASH_LAST = 8'(RESPAWN_STEPS - 1);
    localparam logic [6:0]            X_SPAWN    = 7'(SPAWN_X);
    localparam logic [5:0]            Y_SPAWN    = 6'(SPAWN_Y);
    localparam logic signed [7:0]     X_LIM      = 8'(X_MAX);
    localparam logic signed [6:0]     Y_LIM      = 7'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CRASH
    } state_e;

    state_e            state_q;
    logic [3:0]        btn_meta_q;   // {up, down, left, right}
    logic [3:0]        btn_sync_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        crash_cnt_q;
    logic [6:0]        x_q;
    logic [5:0]        y_q;
    logic              moving_q;
    logic              respawn_q;

    logic              step_tick;
    logic signed [7:0] x_ext;
    logic signed [7:0] x_nxt;
    logic signed [6:0] y_ext;
    logic signed [6:0] y_nxt;
    logic [6:0]        x_step;
    logic [5:0]        y_step;

    // Two-flop synchronizers for the asynchronous buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            btn_meta_q <= {btn_up, btn_down, btn_left, btn_right};
            btn_sync_q <= btn_meta_q;
        end
    end

    // Step tick fires on the last count of the divider while not idle
    always_comb step_tick = (state_q != IDLE) && (cnt_q == CNT_LAST);

    // Candidate position for the next step: signed +/-1 per axis, then limit
    always_comb begin
        x_ext  = signed'({1'b0, x_q});
        y_ext  = signed'({1'b0, y_q});
        x_nxt  = x_ext;
        y_nxt  = y_ext;
        x_step = x_q;
        y_step = y_q;
        case (btn_sync_q[1:0])
            2'b01:   x_nxt = x_ext + 8'sd1;
            2'b10:   x_nxt = x_ext - 8'sd1;
            default: x_nxt = x_ext;
        endcase
        case (btn_sync_q[3:2])
            2'b10:   y_nxt = y_ext - 7'sd1;
            2'b01:   y_nxt = y_ext + 7'sd1;
            default: y_nxt = y_ext;
        endcase
`ifdef PLAYER_WRAP_EN
        if (x_nxt < 8'sd0)      x_step = X_LIM[6:0];
        else if (x_nxt > X_LIM) x_step = '0;
        else                    x_step = x_nxt[6:0];
`else
        if (x_nxt < 8'sd0)      x_step = '0;
        else if (x_nxt > X_LIM) x_step = X_LIM[6:0];
        else                    x_step = x_nxt[6:0];
`endif
        if (y_nxt < 7'sd0)      y_step = '0;
        else if (y_nxt > Y_LIM) y_step = Y_LIM[5:0];
        else                    y_step = y_nxt[5:0];
    end

    // Motion FSM: divider, crash timer, position and pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            crash_cnt_q <= '0;
            x_q         <= X_SPAWN;
            y_q         <= Y_SPAWN;
            moving_q    <= 1'b0;
            respawn_q   <= 1'b0;
        end else begin
            moving_q  <= 1'b0;
            respawn_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (enable) state_q <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= step_tick ? '0 : cnt_q + 1'b1;
                        if (crash_in) begin
                            state_q     <= CRASH;
                            crash_cnt_q <= '0;
                        end else if (step_tick) begin
                            x_q      <= x_step;
                            y_q      <= y_step;
                            moving_q <= (x_step != x_q) || (y_step != y_q);
                        end
                    end
                end
                CRASH: begin
                    if (!enable) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        x_q       <= X_SPAWN;
                        y_q       <= Y_SPAWN;
                        respawn_q <= 1'b1;
                    end else begin
                        cnt_q <= step_tick ? '0 : cnt_q + 1'b1;
                        if (step_tick) begin
                            // Final tick respawns directly rather than waiting
                            // one more cycle for the counter to read RESPAWN_STEPS
                            if (crash_cnt_q == CRASH_LAST) begin
                                state_q   <= RUN;
                                x_q       <= X_SPAWN;
                                y_q       <= Y_SPAWN;
                                respawn_q <= 1'b1;
                            end else begin
                                crash_cnt_q <= crash_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign player_x       = x_q;
    assign player_y       = y_q;
    assign player_moving  = moving_q;
    assign player_crashed = (state_q == CRASH);
    assign respawn_pulse  = respawn_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl with STEP_DIV=4, RESPAWN_STEPS=3.
module tb_player_motion_ctrl;

    localparam int SD = 4;
    localparam int RS = 3;
    localparam int XM = 86;
    localparam int YM = 56;
    localparam int SX = 0;
    localparam int SY = 28;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       crash_in = 1'b0;
    logic [6:0] player_x;
    logic [5:0] player_y;
    logic       player_moving;
    logic       player_crashed;
    logic       respawn_pulse;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: activity (0 stopped, 1 playing, 2 crashed),
    // cycles since the last tick, ticks spent crashed, position, pulses.
    int m_act, m_phase, m_ticks, m_x, m_y, m_mov, m_resp;
    // Button history: values seen one and two edges ago, {up,down,left,right}
    int h1[4];
    int h2[4];

    player_motion_ctrl #(
        .STEP_DIV(SD),
        .X_MAX(XM),
        .Y_MAX(YM),
        .SPAWN_X(SX),
        .SPAWN_Y(SY),
        .RESPAWN_STEPS(RS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .crash_in(crash_in),
        .player_x(player_x),
        .player_y(player_y),
        .player_moving(player_moving),
        .player_crashed(player_crashed),
        .respawn_pulse(respawn_pulse)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_act = 0; m_phase = 0; m_ticks = 0;
        m_x = SX; m_y = SY; m_mov = 0; m_resp = 0;
        for (int i = 0; i < 4; i++) begin h1[i] = 0; h2[i] = 0; end
    endfunction

    function automatic void respawn();
        m_x = SX; m_y = SY; m_resp = 1;
    endfunction

    // Behaviour of one clock edge, from the game rules
    function automatic void model_edge();
        bit tick;
        int dx, dy, nx, ny;
        tick = (m_act != 0) && (m_phase == SD - 1);
        dx = h2[3] - h2[2];   // right minus left
        dy = h2[1] - h2[0];   // down minus up
        m_mov = 0; m_resp = 0;
        if (m_act == 0) begin
            m_phase = 0;
            if (enable) m_act = 1;
        end else if (!enable) begin
            if (m_act == 2) respawn();
            m_act = 0; m_phase = 0;
        end else begin
            m_phase = tick ? 0 : m_phase + 1;
            if (m_act == 1) begin
                if (crash_in) begin
                    m_act = 2; m_ticks = 0;
                end else if (tick) begin
                    nx = m_x + dx;
                    ny = m_y + dy;
`ifdef PLAYER_WRAP_EN
                    if (nx < 0) nx = XM;
                    else if (nx > XM) nx = 0;
`else
                    if (nx < 0) nx = 0;
                    else if (nx > XM) nx = XM;
`endif
                    if (ny < 0) ny = 0;
                    else if (ny > YM) ny = YM;
                    m_mov = (nx != m_x || ny != m_y) ? 1 : 0;
                    m_x = nx; m_y = ny;
                end
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == RS) begin
                    respawn();
                    m_act = 1;
                end
            end
        end
        h2 = h1;
        h1[0] = int'(btn_up); h1[1] = int'(btn_down);
        h1[2] = int'(btn_left); h1[3] = int'(btn_right);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("player_x", int'(player_x), m_x);
        chk("player_y", int'(player_y), m_y);
        chk("player_moving", int'(player_moving), m_mov);
        chk("player_crashed", int'(player_crashed), (m_act == 2) ? 1 : 0);
        chk("respawn_pulse", int'(respawn_pulse), m_resp);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic set_btn(input int u, input int d, input int l, input int r);
        btn_up = u[0]; btn_down = d[0]; btn_left = l[0]; btn_right = r[0];
    endtask

    initial begin
        int n;
        int b;
        model_reset();

        // Reset state
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // Hold right: x advances once per step, y stays put
        enable = 1'b1;
        set_btn(0, 0, 0, 1);
        repeat (6 * SD) cycle();

        // Hold up for 40 ticks: y walks to 0 and sticks there
        set_btn(1, 0, 0, 0);
        repeat (40 * SD) cycle();
        chk("y_clamped_top", int'(player_y), 0);

        // Hold right long enough to reach the right wall and push against it
        set_btn(0, 0, 0, 1);
        repeat (90 * SD) cycle();

        // Left+right cancel, down still steps
        set_btn(0, 1, 1, 1);
        repeat (10 * SD) cycle();

        // Crash on a tick cycle blocks that step
        n = 0;
        while (!(m_act == 1 && m_phase == SD - 1) && n < 20) begin
            cycle(); n++;
        end
        chk("tick_found", (n < 20) ? 1 : 0, 1);
        crash_in = 1'b1;
        cycle();
        crash_in = 1'b0;
        chk("crash_blocks_step", int'(player_moving), 0);
        chk("crashed_flag", int'(player_crashed), 1);
        n = 0;
        do begin cycle(); n++; end while (!respawn_pulse && n < 40);
        chk("respawn_latency", n, RS * SD);
        chk("respawn_x", int'(player_x), SX);
        chk("respawn_y", int'(player_y), SY);
        chk("respawn_uncrashed", int'(player_crashed), 0);
        cycle();
        chk("respawn_one_cycle", int'(respawn_pulse), 0);

        // Pause and resume: first step comes exactly STEP_DIV cycles later
        set_btn(0, 0, 0, 1);
        repeat (3) cycle();
        enable = 1'b0;
        repeat (5) cycle();
        enable = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!player_moving && n < 20);
        chk("reenable_latency", n, SD + 1);

        // Randomized play
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = int'($urandom_range(0, 15));
                set_btn(b >> 3, b >> 2, b >> 1, b);
            end
            crash_in = ($urandom_range(0, 39) == 0);
            if (enable && $urandom_range(0, 99) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            cycle();
        end
        crash_in = 1'b0;
        enable = 1'b1;
        cycle();

        // Asynchronous reset in the middle of a crash
        crash_in = 1'b1;
        cycle();
        crash_in = 1'b0;
        cycle();
        cycle();
        chk("in_crash_before_reset", int'(player_crashed), 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3 * SD) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
